keypad_matrix_scanner: RTL and testbench

- Reader for the board's 5x4 button matrix on BTN_X[4:0] / BTN_Y[3:0].
- Drives one X line low at a time and samples the pulled-up Y lines, debounces all 20 keys, and queues press events.
- Presents one key code at a time to game control logic over a valid/ack handshake.
- The top level owns the tristate pads; this block sees only the split drive-enable and sample signals.

---
 rtl/keypad_matrix_scanner_pkg.sv | 25 ++
 rtl/keypad_matrix_scanner_if.sv | 11 +
 rtl/keypad_matrix_scanner_key_debounce.sv | 48 ++++
 rtl/keypad_matrix_scanner.sv | 147 ++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared sizes, scan FSM encoding and the pending-mask priority encoder
// for the keypad matrix scanner.
package keypad_pkg;

    localparam int NUM_ROWS   = 5;
    localparam int NUM_COLS   = 4;
    localparam int NUM_KEYS   = 20;
    localparam int KEY_CODE_W = 5;
    localparam int ROW_W      = 3;

    typedef enum logic [1:0] {
        S_DRIVE     = 2'd0,
        S_SAMPLE    = 2'd1,
        S_FRAME_END = 2'd2
    } scan_state_t;

    // Lowest set index wins so simultaneous presses drain in ascending order.
    function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        lowest_set = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (v[k]) lowest_set = KEY_CODE_W'(k);
        end
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Key event handshake between the scanner (master) and game control (slave).
interface keypad_matrix_scanner_if;

    logic [keypad_pkg::KEY_CODE_W-1:0] key_code;
    logic                              key_valid;
    logic                              key_ack;

    modport master (output key_code, output key_valid, input key_ack);
    modport slave  (input key_code, input key_valid, output key_ack);

endinterface

// File: rtl/keypad_matrix_scanner_key_debounce.sv
// Per-key saturating frame integrator; stable flips only at the rails,
// rise_pulse marks the frame-end cycle in which stable goes 0->1.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_end,
    input  logic raw,
    output logic stable,
    output logic rise_pulse
);

    localparam logic [3:0] TOP = 4'(DEBOUNCE_SCANS);

    logic [3:0] integ;
    logic [3:0] integ_next;
    logic       stable_next;

    function automatic logic [3:0] sat_step(input logic [3:0] v, input logic up);
        if (up) return (v == TOP) ? v : v + 4'd1;
        else    return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    always_comb begin
        integ_next  = integ;
        stable_next = stable;
        if (frame_end) begin
            integ_next = sat_step(integ, raw);
            if (integ_next == TOP)       stable_next = 1'b1;
            else if (integ_next == 4'd0) stable_next = 1'b0;
        end
    end

    // Combinational so the parent can queue the event on the same edge stable sets.
    assign rise_pulse = stable_next & ~stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            integ  <= '0;
            stable <= 1'b0;
        end else begin
            integ  <= integ_next;
            stable <= stable_next;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 5x4 keypad matrix scanner: row drive/sample FSM, per-key debounce,
// pending press queue and a single-entry valid/ack key event output.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [NUM_ROWS-1:0]         row_oe,
    input  logic [NUM_COLS-1:0]         col_in,
    keypad_matrix_scanner_if.master     key_if,
    output logic [NUM_KEYS-1:0]         key_state,
    output logic                        overflow
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV - 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 2);

    scan_state_t          state, state_next;
    logic [ROW_W-1:0]     row, row_next;
    logic [DIV_W-1:0]     div, div_next;
    logic [NUM_KEYS-1:0]  raw;
    logic                 frame_end;

    logic [NUM_KEYS-1:0]  stable_vec;
    logic [NUM_KEYS-1:0]  rise;
    logic [NUM_KEYS-1:0]  pending, pending_next;
    logic [NUM_KEYS-1:0]  take_mask, hold_mask, dup;
    logic                 take;
    logic [KEY_CODE_W-1:0] take_code;

    // Reset parks the FSM in FRAME_END so the first cycle out of reset drives row 0
    // for the full SCAN_DIV period; with zeroed integrators that frame end is a no-op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FRAME_END;
            row   <= '0;
            div   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
            div   <= div_next;
        end
    end

    always_comb begin
        state_next = state;
        row_next   = row;
        div_next   = div;
        unique case (state)
            S_DRIVE: begin
                if (div == DIV_LAST) begin
                    state_next = S_SAMPLE;
                    div_next   = '0;
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end
            S_SAMPLE: begin
                if (row == ROW_W'(NUM_ROWS - 1)) begin
                    state_next = S_FRAME_END;
                end else begin
                    row_next   = row + ROW_W'(1);
                    state_next = S_DRIVE;
                end
            end
            S_FRAME_END: begin
                row_next   = '0;
                state_next = S_DRIVE;
            end
            default: state_next = S_FRAME_END;
        endcase
    end

    always_comb begin
        row_oe = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_oe[r] = (state != S_FRAME_END) && (row == ROW_W'(r));
        end
    end

    assign frame_end = (state == S_FRAME_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            raw <= '0;
        end else if (state == S_SAMPLE) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (row == ROW_W'(r)) begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        raw[r*NUM_COLS + c] <= ~col_in[c];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .frame_end  (frame_end),
            .raw        (raw[k]),
            .stable     (stable_vec[k]),
            .rise_pulse (rise[k])
        );
    end

    assign key_state = stable_vec;

    // A press already queued or currently on offer is merged and flagged as lost.
    always_comb begin
        take      = (pending != '0) && (!key_if.key_valid || key_if.key_ack);
        take_code = lowest_set(pending);
        take_mask = '0;
        hold_mask = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            take_mask[k] = take && (take_code == KEY_CODE_W'(k));
            hold_mask[k] = key_if.key_valid && (key_if.key_code == KEY_CODE_W'(k));
        end
        dup          = rise & (pending | hold_mask);
        pending_next = (pending & ~take_mask) | (rise & ~dup);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending          <= '0;
            overflow         <= 1'b0;
            key_if.key_valid <= 1'b0;
            key_if.key_code  <= '0;
        end else begin
            pending <= pending_next;
            if (dup != '0) overflow <= 1'b1;
            if (take) begin
                key_if.key_valid <= 1'b1;
                key_if.key_code  <= take_code;
            end else if (key_if.key_ack) begin
                key_if.key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (21-cycle frame).
module tb_keypad_matrix_scanner;

    logic        clk;
    logic        rst;
    logic [4:0]  row_oe;
    logic [3:0]  col_in;
    logic [19:0] key_state;
    logic        overflow;
    logic [19:0] pressed;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    keypad_matrix_scanner_if kif ();

    keypad_matrix_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_oe    (row_oe),
        .col_in    (col_in),
        .key_if    (kif.master),
        .key_state (key_state),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: a held key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row_oe[r] && pressed[r*4 + c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    // Leaves the bench at cycle 0: first cycle with row 0 driven.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        cyc = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_row_oe"},    32'(row_oe), 32'h0);
        check_eq({tag, "_key_code"},  32'(kif.key_code), 32'h0);
        check_eq({tag, "_key_valid"}, 32'(kif.key_valid), 32'h0);
        check_eq({tag, "_key_state"}, 32'(key_state), 32'h0);
        check_eq({tag, "_overflow"},  32'(overflow), 32'h0);
    endtask

    initial begin
        logic [4:0] exp_oe;
        rst         = 1'b1;
        pressed     = '0;
        kif.key_ack = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        cyc = 0;
        check_eq("first_row_oe", 32'(row_oe), 32'h01);

        // Scan sequencing with ack toggling and no keys.
        for (int i = 0; i < 42; i++) begin
            exp_oe = ((i % 21) < 20) ? 5'(5'b00001 << ((i % 21) / 4)) : 5'b00000;
            check_eq("scan_row_oe", 32'(row_oe), 32'(exp_oe));
            check_eq("scan_no_valid", 32'(kif.key_valid), 32'h0);
            kif.key_ack = ~kif.key_ack;
            step();
        end
        kif.key_ack = 1'b0;
        check_eq("scan_wrap_row_oe", 32'(row_oe), 32'h01);

        // Basic press of key 9 (row 2, col 1).
        do_reset();
        pressed = 20'(1) << 9;
        goto(62);
        check_eq("basic_state_before", 32'(key_state), 32'h0);
        step();
        check_eq("basic_state_set", 32'(key_state), 32'h200);
        check_eq("basic_valid_lag", 32'(kif.key_valid), 32'h0);
        step();
        check_eq("basic_valid", 32'(kif.key_valid), 32'h1);
        check_eq("basic_code", 32'(kif.key_code), 32'd9);
        kif.key_ack = 1'b1;
        step();
        kif.key_ack = 1'b0;
        check_eq("basic_acked", 32'(kif.key_valid), 32'h0);
        goto(110);
        check_eq("basic_no_repeat", 32'(kif.key_valid), 32'h0);
        check_eq("basic_still_held", 32'(key_state), 32'h200);

        // Bounce: key 9 present on alternate frames only.
        do_reset();
        for (int f = 0; f < 10; f++) begin
            pressed = (f % 2 == 0) ? (20'(1) << 9) : 20'h0;
            goto(21 * (f + 1));
            check_eq("bounce_valid", 32'(kif.key_valid), 32'h0);
        end
        check_eq("bounce_state", 32'(key_state), 32'h0);
        pressed = '0;

        // Simultaneous keys 3 and 17 with ack tied high.
        do_reset();
        pressed     = (20'(1) << 3) | (20'(1) << 17);
        kif.key_ack = 1'b1;
        goto(63);
        check_eq("simul_state", 32'(key_state), 32'h20008);
        step();
        check_eq("simul_valid0", 32'(kif.key_valid), 32'h1);
        check_eq("simul_code0", 32'(kif.key_code), 32'd3);
        step();
        check_eq("simul_valid1", 32'(kif.key_valid), 32'h1);
        check_eq("simul_code1", 32'(kif.key_code), 32'd17);
        step();
        check_eq("simul_drained", 32'(kif.key_valid), 32'h0);
        check_eq("simul_overflow", 32'(overflow), 32'h0);
        kif.key_ack = 1'b0;

        // Overflow: key 5 reported, released, pressed again with no ack.
        do_reset();
        pressed = 20'(1) << 5;
        goto(63);
        pressed = '0;
        step();
        check_eq("ovf_first_valid", 32'(kif.key_valid), 32'h1);
        check_eq("ovf_first_code", 32'(kif.key_code), 32'd5);
        goto(126);
        check_eq("ovf_released", 32'(key_state), 32'h0);
        pressed = 20'(1) << 5;
        goto(188);
        check_eq("ovf_not_yet", 32'(overflow), 32'h0);
        step();
        check_eq("ovf_set", 32'(overflow), 32'h1);
        check_eq("ovf_valid", 32'(kif.key_valid), 32'h1);
        check_eq("ovf_code", 32'(kif.key_code), 32'd5);
        check_eq("ovf_state", 32'(key_state), 32'h20);
        goto(230);
        check_eq("ovf_sticky", 32'(overflow), 32'h1);
        pressed = '0;

        // Reset mid-frame with key 14 (row 3, col 2) held.
        do_reset();
        pressed = 20'(1) << 14;
        goto(64);
        check_eq("midrst_pre_code", 32'(kif.key_code), 32'd14);
        goto(76);
        check_eq("midrst_row3", 32'(row_oe), 32'h08);
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        step();
        cyc = 0;
        check_eq("midrst_restart_row", 32'(row_oe), 32'h01);
        goto(62);
        check_eq("midrst_fresh_before", 32'(key_state), 32'h0);
        check_eq("midrst_no_valid", 32'(kif.key_valid), 32'h0);
        step();
        check_eq("midrst_fresh_state", 32'(key_state), 32'h4000);
        step();
        check_eq("midrst_fresh_valid", 32'(kif.key_valid), 32'h1);
        check_eq("midrst_fresh_code", 32'(kif.key_code), 32'd14);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
